// File: rtl/arbitrate_round.sv
// ---------------------------------------------------------------------------
// arbitrate_round
//
// Round-based N-to-1 arbiter. Every enabled, requesting channel is served
// exactly once per round. The granted channel's data word is forwarded on the
// m stream and its index on the n stream. Each stream has its own handshake.
// When every enabled channel has been served, done pulses for one cycle and a
// fresh round starts on its own.
//
// Optional feature macro: ARBITRATE_ROUND_RR_EN
//   defined   : grant = first eligible channel at or after a rotating pointer
//   undefined : grant = lowest-index eligible channel (no pointer register)
//
// Parameters
//   W      data width per channel
//   N      channel count (>= 2)
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   en       in   [N]    channel enable mask
//   s_stb    in   [N]    per-channel request strobe
//   s_dat    in   [N*W]  per-channel data, channel i at [i*W +: W]
//   s_rdy    out  [N]    per-channel accept, one-hot or zero
//   n_rdy    in          index consumer ready
//   n_stb    out         index valid
//   n_dat    out  [IW]   granted channel index
//   m_rdy    in          data consumer ready
//   m_stb    out         data valid
//   m_dat    out  [W]    granted channel data
//   done     out         one-cycle pulse after a round completes
// ---------------------------------------------------------------------------
module arbitrate_round #(
    parameter int W = 16,
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    en,
    input  logic [N-1:0]    s_stb,
    input  logic [N*W-1:0]  s_dat,
    output logic [N-1:0]    s_rdy,
    input  logic            n_rdy,
    output logic            n_stb,
    output logic [IW-1:0]   n_dat,
    input  logic            m_rdy,
    output logic            m_stb,
    output logic [W-1:0]    m_dat,
    output logic            done
);

    logic [N-1:0]  r_served;
    logic          r_m_stb;
    logic          r_n_stb;
    logic [W-1:0]  r_m_dat;
    logic [IW-1:0] r_n_dat;
    logic          r_done;

    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_grant_oh;
    logic [N-1:0]  w_served_next;
    logic [IW-1:0] w_grant;
    logic          w_found;
    logic          w_slot_free;
    logic          w_capture;
    logic          w_complete;

    assign w_elig      = s_stb & en & ~r_served;
    // Both output slots must be able to take a new word before any capture.
    assign w_slot_free = (~r_m_stb | m_rdy) & (~r_n_stb | n_rdy);

`ifdef ARBITRATE_ROUND_RR_EN
    logic [IW-1:0] r_ptr;
    int            w_idx;

    // Scan N positions starting at the pointer, wrapping at N (not at 2**IW),
    // so indices >= N are never produced.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_grant = IW'(w_idx);
            end
        end
    end
`else
    // Descending scan: the last hit is the lowest eligible index.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found = 1'b1;
                w_grant = IW'(i);
            end
        end
    end
`endif

    assign w_capture = w_found & w_slot_free;

    always_comb begin
        w_grant_oh = '0;
        if (w_capture) begin
            w_grant_oh[w_grant] = 1'b1;
        end
    end

    assign w_served_next = r_served | w_grant_oh;
    // Channels that are disabled count as served; an empty mask never completes.
    assign w_complete    = (&(w_served_next | ~en)) & (|en);

    // s_rdy is combinational, so it is gated by reset to keep it low while
    // rst is asserted even if a request is present.
    assign s_rdy = rst ? w_grant_oh : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_stb  <= 1'b0;
            r_n_stb  <= 1'b0;
            r_m_dat  <= '0;
            r_n_dat  <= '0;
            r_served <= '0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            if (w_capture) begin
                r_m_dat <= s_dat[int'(w_grant)*W +: W];
                r_n_dat <= w_grant;
                r_m_stb <= 1'b1;
                r_n_stb <= 1'b1;
            end else begin
                // The two streams drain independently of each other.
                if (m_rdy) begin
                    r_m_stb <= 1'b0;
                end
                if (n_rdy) begin
                    r_n_stb <= 1'b0;
                end
            end
            // Round clear wins over recording the completing grant.
            if (w_complete) begin
                r_served <= '0;
            end else begin
                r_served <= w_served_next;
            end
            r_done <= w_complete;
        end
    end

`ifdef ARBITRATE_ROUND_RR_EN
    // The pointer is not reset at round end, so successive rounds rotate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_capture) begin
            r_ptr <= (w_grant == IW'(N - 1)) ? '0 : w_grant + IW'(1);
        end
    end
`endif

    assign m_stb = r_m_stb;
    assign n_stb = r_n_stb;
    assign m_dat = r_m_dat;
    assign n_dat = r_n_dat;
    assign done  = r_done;

endmodule

// File: tb/tb_arbitrate_round.sv
// ---------------------------------------------------------------------------
// tb_arbitrate_round
//
// Directed bench for arbitrate_round (W=16, N=4). Expected grants are pushed
// into scoreboard queues before stimulus; a monitor pops and compares on
// every m/n handshake. Expected orders follow ARBITRATE_ROUND_RR_EN.
// ---------------------------------------------------------------------------
module tb_arbitrate_round;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        int           ch;
        logic [W-1:0] dat;
        logic         dn;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    en;
    logic [N-1:0]    s_stb;
    logic [N*W-1:0]  s_dat;
    logic [N-1:0]    s_rdy;
    logic            n_rdy;
    logic            n_stb;
    logic [IW-1:0]   n_dat;
    logic            m_rdy;
    logic            m_stb;
    logic [W-1:0]    m_dat;
    logic            done;

    exp_t         exp_n[$];
    exp_t         exp_m[$];
    logic [W-1:0] chdat[N];
    int           n_checks = 0;
    int           n_errors = 0;
    int           done_cnt = 0;

    arbitrate_round #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .n_rdy (n_rdy),
        .n_stb (n_stb),
        .n_dat (n_dat),
        .m_rdy (m_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int ch, input logic dn);
        exp_t e;
        e.ch  = ch;
        e.dat = chdat[ch];
        e.dn  = dn;
        exp_n.push_back(e);
        exp_m.push_back(e);
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            s_dat[i*W +: W] = chdat[i];
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count grants seen on s_rdy (bounded), then drop all requests right
    // after the edge that takes the last one.
    task automatic wait_grants(input int n, input string name);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (|s_rdy) cnt++;
        end
        check({name, "_grants"}, cnt, n);
        @(posedge clk);
        #1;
        s_stb = '0;
    endtask

    // Scoreboard monitor: compare on each handshake, away from the clock edge.
    always @(negedge clk) begin
        exp_t e_m;
        exp_t e_n;
        if (rst) begin
            if (m_stb && m_rdy) begin
                if (exp_m.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL m_unexpected: got %0h required no transfer", m_dat);
                end else begin
                    e_m = exp_m.pop_front();
                    check("m_dat", m_dat, e_m.dat);
                end
            end
            if (n_stb && n_rdy) begin
                if (exp_n.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL n_unexpected: got %0h required no transfer", n_dat);
                end else begin
                    e_n = exp_n.pop_front();
                    check("n_dat", n_dat, e_n.ch);
                    check("done_at_n", done, e_n.dn);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        en    = 4'hF;
        s_stb = 4'hF;
        m_rdy = 1'b1;
        n_rdy = 1'b1;
        for (int i = 0; i < N; i++) chdat[i] = W'(i * 16'h11);
        drive_data();
        rst = 1'b0;
        step(2);

        // Reset state, with requests already present
        check("rst_s_rdy", s_rdy, 0);
        check("rst_m_stb", m_stb, 0);
        check("rst_n_stb", n_stb, 0);
        check("rst_m_dat", m_dat, 0);
        check("rst_n_dat", n_dat, 0);
        check("rst_done",  done,  0);

        // T1: all requesting, both ready: two full rounds in index order
        for (int r = 0; r < 2; r++) begin
            push(0, 1'b0); push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
        end
        rst = 1'b1;
        wait_grants(8, "t1");
        step(4);
        check("t1_done_cnt", done_cnt, 2);
        check("t1_queue", exp_n.size(), 0);

        // T2: ch2 requests alone first, then everyone
        chdat[0] = 16'hA000; chdat[1] = 16'hB111; chdat[2] = 16'hC222; chdat[3] = 16'hD333;
        drive_data();
`ifdef ARBITRATE_ROUND_RR_EN
        push(2, 1'b0); push(3, 1'b0); push(0, 1'b0); push(1, 1'b1);
`else
        push(2, 1'b0); push(0, 1'b0); push(1, 1'b0); push(3, 1'b1);
`endif
        s_stb = 4'b0100;
        wait_grants(1, "t2a");
        s_stb = 4'hF;
        wait_grants(3, "t2b");
        step(4);
        check("t2_done_cnt", done_cnt, 3);
        check("t2_queue", exp_n.size(), 0);

        // T3: n consumer stalls for 3 cycles after a capture, m stays ready
`ifdef ARBITRATE_ROUND_RR_EN
        push(2, 1'b0); push(3, 1'b0); push(0, 1'b0); push(1, 1'b1);
`else
        push(0, 1'b0); push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
`endif
        n_rdy = 1'b0;
        s_stb = 4'hF;
        @(negedge clk);
`ifdef ARBITRATE_ROUND_RR_EN
        check("t3_first_grant", s_rdy, 4'b0100);
`else
        check("t3_first_grant", s_rdy, 4'b0001);
`endif
        @(negedge clk);
        check("t3_c1_m_stb", m_stb, 1);
        check("t3_c1_n_stb", n_stb, 1);
        check("t3_c1_s_rdy", s_rdy, 0);
        @(negedge clk);
        check("t3_c2_m_stb", m_stb, 0);
        check("t3_c2_n_stb", n_stb, 1);
`ifdef ARBITRATE_ROUND_RR_EN
        check("t3_c2_n_dat", n_dat, 2);
`else
        check("t3_c2_n_dat", n_dat, 0);
`endif
        check("t3_c2_s_rdy", s_rdy, 0);
        @(negedge clk);
        check("t3_c3_n_stb", n_stb, 1);
        check("t3_c3_s_rdy", s_rdy, 0);
        @(posedge clk);
        #1;
        n_rdy = 1'b1;
        @(negedge clk);
`ifdef ARBITRATE_ROUND_RR_EN
        check("t3_resume_grant", s_rdy, 4'b1000);
`else
        check("t3_resume_grant", s_rdy, 4'b0010);
`endif
        wait_grants(2, "t3");
        step(4);
        check("t3_done_cnt", done_cnt, 4);
        check("t3_queue", exp_n.size(), 0);

        // T4a: ch2 disabled; a round is three grants
        en = 4'b1011;
`ifdef ARBITRATE_ROUND_RR_EN
        push(3, 1'b0); push(0, 1'b0); push(1, 1'b1);
`else
        push(0, 1'b0); push(1, 1'b0); push(3, 1'b1);
`endif
        s_stb = 4'hF;
        wait_grants(3, "t4a");
        step(4);
        check("t4a_done_cnt", done_cnt, 5);
        check("t4a_queue", exp_n.size(), 0);

        // T4b: serve 0 and 1, then disable ch3 before it is served
        push(0, 1'b0); push(1, 1'b0);
        s_stb = 4'b0011;
        wait_grants(2, "t4b");
        step(4);
        check("t4b_no_done", done_cnt, 5);
        en = 4'b0011;
        @(negedge clk);
        check("t4b_done_c0", done, 0);
        @(negedge clk);
        check("t4b_done_c1", done, 1);
        check("t4b_m_stb_c1", m_stb, 0);
        @(negedge clk);
        check("t4b_done_c2", done, 0);
        check("t4b_done_cnt", done_cnt, 6);
        check("t4b_queue", exp_n.size(), 0);

        // en == 0: no grants, no done
        en    = 4'h0;
        s_stb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("en0_s_rdy", s_rdy, 0);
        end
        check("en0_done_cnt", done_cnt, 6);

        // T5: reset while a word is held in the output slots
        @(posedge clk);
        #1;
        en    = 4'hF;
        m_rdy = 1'b0;
        n_rdy = 1'b0;
        @(negedge clk);
`ifdef ARBITRATE_ROUND_RR_EN
        check("t5_grant", s_rdy, 4'b0100);
`else
        check("t5_grant", s_rdy, 4'b0001);
`endif
        @(negedge clk);
        check("t5_m_stb_held", m_stb, 1);
        check("t5_stall_s_rdy", s_rdy, 0);
        @(negedge clk);
        check("t5_stall_s_rdy2", s_rdy, 0);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_m_stb", m_stb, 0);
        check("t5_rst_n_stb", n_stb, 0);
        check("t5_rst_m_dat", m_dat, 0);
        check("t5_rst_n_dat", n_dat, 0);
        check("t5_rst_s_rdy", s_rdy, 0);
        check("t5_rst_done",  done,  0);
        push(0, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        m_rdy = 1'b1;
        n_rdy = 1'b1;
        @(negedge clk);
        check("t5_first_grant", s_rdy, 4'b0001);
        wait_grants(0, "t5");
        step(4);
        check("t5_queue_n", exp_n.size(), 0);
        check("t5_queue_m", exp_m.size(), 0);
        check("final_done_cnt", done_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
